// File: rtl/lt24_system_nios2_mulx_seq.sv
// rtl/lt24_system_nios2_mulx_seq.sv - 32x32 multiply sequencer on one 16x16 partial-product multiplier
module lt24_system_nios2_mulx_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        mul_start,
  input  logic [1:0]  mul_op,
  input  logic [31:0] mul_src1,
  input  logic [31:0] mul_src2,
  output logic        mul_busy,
  output logic        mul_done,
  output logic [31:0] mul_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE0, S_ISSUE1, S_ISSUE2, S_ISSUE3, S_DRAIN, S_CORR, S_DONE
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] prod_q, prod_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [15:0] mul_x, mul_y;
  logic [31:0] corr_hi;

  // Next-state, partial-product issue, accumulation and result selection
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    mul_x    = 16'h0;
    mul_y    = 16'h0;
    corr_hi  = acc_q[63:32];
    case (state_q)
      S_IDLE: begin
        if (mul_start) begin
          a_d     = mul_src1;
          b_d     = mul_src2;
          op_d    = mul_op;
          acc_d   = 64'h0;
          state_d = S_ISSUE0;
        end
      end
      S_ISSUE0: begin
        mul_x   = a_q[15:0];
        mul_y   = b_q[15:0];
        state_d = S_ISSUE1;
      end
      S_ISSUE1: begin
        mul_x   = a_q[15:0];
        mul_y   = b_q[31:16];
        acc_d   = acc_q + {32'h0, prod_q};
        state_d = S_ISSUE2;
      end
      S_ISSUE2: begin
        mul_x   = a_q[31:16];
        mul_y   = b_q[15:0];
        acc_d   = acc_q + ({32'h0, prod_q} << 16);
        state_d = S_ISSUE3;
      end
      S_ISSUE3: begin
        mul_x   = a_q[31:16];
        mul_y   = b_q[31:16];
        acc_d   = acc_q + ({32'h0, prod_q} << 16);
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        acc_d   = acc_q + {prod_q, 32'h0};
        state_d = S_CORR;
      end
      S_CORR: begin
        // Signed high word = unsigned high word minus the operands whose sign bit counts as negative
        if (op_q[1] && a_q[31]) corr_hi = corr_hi - b_q;
        if ((op_q == OP_MULXSS) && b_q[31]) corr_hi = corr_hi - a_q;
        acc_d   = {corr_hi, acc_q[31:0]};
        state_d = S_DONE;
      end
      S_DONE: begin
        result_d = (op_q == OP_MUL) ? acc_q[31:0] : acc_q[63:32];
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    prod_d = {16'h0, mul_x} * {16'h0, mul_y};
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      op_q     <= 2'b00;
      acc_q    <= 64'h0;
      prod_q   <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign mul_busy   = busy_q;
  assign mul_done   = done_q;
  assign mul_result = result_q;

endmodule

// File: tb/tb_lt24_system_nios2_mulx_seq.sv
// tb/tb_lt24_system_nios2_mulx_seq.sv - directed-vector bench for the multiply sequencer
module tb_lt24_system_nios2_mulx_seq;

  logic        clk;
  logic        reset;
  logic        mul_start;
  logic [1:0]  mul_op;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic        mul_busy;
  logic        mul_done;
  logic [31:0] mul_result;

  int checks;
  int failures;

  lt24_system_nios2_mulx_seq dut (
    .clk        (clk),
    .reset      (reset),
    .mul_start  (mul_start),
    .mul_op     (mul_op),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .mul_busy   (mul_busy),
    .mul_done   (mul_done),
    .mul_result (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; accepts one op, scrambles inputs after accept, checks timing and result
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    logic [8:0] busy_bits;
    logic [8:0] done_bits;
    busy_bits = '0;
    done_bits = '0;
    mul_op    = op;
    mul_src1  = a;
    mul_src2  = b;
    mul_start = 1'b1;
    @(posedge clk);
    #1;
    mul_start = 1'b0;
    mul_op    = ~op;
    mul_src1  = ~a;
    mul_src2  = ~b;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      busy_bits[k] = mul_busy;
      done_bits[k] = mul_done;
    end
    check({tag, "_busy"}, {23'h0, busy_bits}, 32'h0000_00FE);
    check({tag, "_done"}, {23'h0, done_bits}, 32'h0000_0080);
    check({tag, "_res"}, mul_result, exp);
  endtask

  initial begin
    logic [31:0] done_mask;
    logic [31:0] noise;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    mul_start = 1'b0;
    mul_op    = 2'b00;
    mul_src1  = 32'h0;
    mul_src2  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, mul_busy}, 32'h0);
    check("rst_done", {31'h0, mul_done}, 32'h0);
    check("rst_res", mul_result, 32'h0);
    reset = 1'b0;

    run_op("uu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mul_a", 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
    run_op("uu_a",  2'b01, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002);
    run_op("ss_a",  2'b11, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002);
    run_op("ss_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("ss_80", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("ss_m2", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    run_op("su_m2", 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    run_op("su_2u", 2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001);

    // mul_start held high: accepts at cycles 0, 8, 16 only; other cycles carry noise operands
    done_mask = '0;
    mul_start = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      done_mask[c] = mul_done;
      if (c == 8)  check("cont_res0", mul_result, 32'h0000_000F);
      if (c == 16) check("cont_res1", mul_result, 32'h000B_000F);
      if (c == 24) check("cont_res2", mul_result, 32'h0000_003F);
      noise = $urandom;
      case (c)
        0:  begin mul_op = 2'b00; mul_src1 = 32'h3;         mul_src2 = 32'h5;         end
        8:  begin mul_op = 2'b00; mul_src1 = 32'h0001_0003; mul_src2 = 32'h0002_0005; end
        16: begin mul_op = 2'b00; mul_src1 = 32'h7;         mul_src2 = 32'h9;         end
        default: begin mul_op = noise[1:0]; mul_src1 = noise; mul_src2 = ~noise; end
      endcase
    end
    mul_start = 1'b0;
    check("cont_done_mask", done_mask, 32'h0080_8080);

    // Reset during ISSUE2 of a fresh operation
    repeat (8) @(negedge clk);
    mul_op    = 2'b00;
    mul_src1  = 32'h3;
    mul_src2  = 32'h5;
    mul_start = 1'b1;
    @(posedge clk);
    #1;
    mul_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'h0, mul_busy}, 32'h0);
    check("abort_res", mul_result, 32'h0);
    done_mask = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      done_mask[k] = mul_done;
    end
    check("abort_nodone", done_mask, 32'h0);
    run_op("post_uu", 2'b01, 32'h3, 32'h5, 32'h0000_0000);
    run_op("post_mul", 2'b00, 32'h3, 32'h5, 32'h0000_000F);

    // Reset and start together: request dropped
    reset     = 1'b1;
    mul_start = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    mul_start = 1'b0;
    check("rst_start_busy", {31'h0, mul_busy}, 32'h0);
    @(negedge clk);
    check("rst_start_busy2", {31'h0, mul_busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
